alarma_buzzer_secuencial: RTL

ALARMA_BUZZER_SECUENCIAL -- requirements
Module: alarma_buzzer_secuencial

---
 rtl/alarma_buzzer_secuencial_if.sv | 28 ++
 rtl/alarma_buzzer_secuencial.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alarma_buzzer_secuencial_if.sv
// Alarm/buzzer signal bundle between the alarm-decision logic and the buzzer sequencer.
// The master drives the request and acknowledge; the slave drives the buzzer status.
interface alarma_buzzer_secuencial_if;
    logic       sAlr;
    logic       sAck;
    logic       sBuz;
    logic       sActiva;
    logic       sSil;
    logic [3:0] nBeeps;

    modport master (
        output sAlr,
        output sAck,
        input  sBuz,
        input  sActiva,
        input  sSil,
        input  nBeeps
    );

    modport slave (
        input  sAlr,
        input  sAck,
        output sBuz,
        output sActiva,
        output sSil,
        output nBeeps
    );
endinterface

// File: rtl/alarma_buzzer_secuencial.sv
// Debounced alarm buzzer sequencer: it confirms the alarm request, plays a
// limited number of on/off beeps, then stays silent until the request drops.
module alarma_buzzer_secuencial #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned ON_CYC    = 8,
    parameter int unsigned OFF_CYC   = 8,
    parameter int unsigned MAX_BEEPS = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    alarma_buzzer_secuencial_if.slave  bus
);

    typedef enum logic [2:0] {
        REPOSO,
        CONFIRMA,
        PITA_ON,
        PITA_OFF,
        SILENCIO
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);
    localparam logic [7:0] ON_LAST  = 8'(ON_CYC - 1);
    localparam logic [7:0] OFF_LAST = 8'(OFF_CYC - 1);
    localparam logic [3:0] MAX_B    = 4'(MAX_BEEPS);

    state_t     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       buz_q, act_q, sil_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            REPOSO: begin
                if (bus.sAlr) begin
                    if (DEB_CYC > 1) begin
                        state_d = CONFIRMA;
                        tmr_d   = 8'd1;
                    end else begin
                        state_d = PITA_ON;
                        tmr_d   = 8'd0;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            CONFIRMA: begin
                if (!bus.sAlr) begin
                    state_d = REPOSO;
                    tmr_d   = 8'd0;
                    cnt_d   = 4'd0;
                end else if (bus.sAck) begin
                    state_d = SILENCIO;
                    tmr_d   = 8'd0;
                end else if (tmr_q == DEB_LAST) begin
                    state_d = PITA_ON;
                    tmr_d   = 8'd0;
                    cnt_d   = cnt_q + 4'd1;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            PITA_ON: begin
                if (!bus.sAlr) begin
                    state_d = REPOSO;
                    tmr_d   = 8'd0;
                    cnt_d   = 4'd0;
                end else if (bus.sAck) begin
                    state_d = SILENCIO;
                    tmr_d   = 8'd0;
                end else if (tmr_q == ON_LAST) begin
                    state_d = PITA_OFF;
                    tmr_d   = 8'd0;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            PITA_OFF: begin
                if (!bus.sAlr) begin
                    state_d = REPOSO;
                    tmr_d   = 8'd0;
                    cnt_d   = 4'd0;
                end else if (bus.sAck) begin
                    state_d = SILENCIO;
                    tmr_d   = 8'd0;
                end else if (tmr_q == OFF_LAST) begin
                    // Last beep played: the counter never exceeds MAX_BEEPS.
                    if (cnt_q == MAX_B) begin
                        state_d = SILENCIO;
                        tmr_d   = 8'd0;
                    end else begin
                        state_d = PITA_ON;
                        tmr_d   = 8'd0;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            SILENCIO: begin
                if (!bus.sAlr) begin
                    state_d = REPOSO;
                    tmr_d   = 8'd0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = REPOSO;
                tmr_d   = 8'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REPOSO;
            tmr_q   <= 8'd0;
            cnt_q   <= 4'd0;
            buz_q   <= 1'b0;
            act_q   <= 1'b0;
            sil_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            buz_q   <= (state_d == PITA_ON);
            act_q   <= (state_d == PITA_ON) || (state_d == PITA_OFF);
            sil_q   <= (state_d == SILENCIO);
        end
    end

    assign bus.sBuz    = buz_q;
    assign bus.sActiva = act_q;
    assign bus.sSil    = sil_q;
    assign bus.nBeeps  = cnt_q;

endmodule
